// File: rtl/dl_tdm_agc_gen2.sv
// -----------------------------------------------------------------------------
// dl_tdm_agc_gen2
// Downlink TDM gain stage. Scales time-interleaved {I,Q} samples of NCH
// antenna carriers by a per-channel unsigned linear gain (unity = 2^FRAC),
// with round-half-up, saturation and a frame-aligned shadow gain update.
//
// Pipeline (fixed 4-cycle latency, input sample -> o_data):
//   S1 input register + gain mux by channel
//   S2 multiply
//   S3 round + shift
//   S4 saturate + output register
//
// Ports:
//   clk_245       datapath clock
//   asy_rst_n     asynchronous reset, active-low
//   i_fram_hd     channel-0 marker, qualified by i_data_valid
//   i_data        {I, Q} two's complement, DW bits each
//   i_data_valid  sample strobe (no back-pressure, full rate)
//   i_gain        target gains, channel k at [k*GW +: GW]
//   i_gain_upd    one-cycle request to adopt i_gain at the next frame head
//   o_fram_hd     frame head aligned with o_data
//   o_data_valid  sample strobe aligned with o_data
//   o_data        scaled {I, Q}; 0 when o_data_valid is low
//   o_ch_idx      channel of o_data; 0 when o_data_valid is low
//   o_sat         I or Q was clipped; 0 when o_data_valid is low
//   o_upd_busy    update pending (FSM in PEND)
//   o_upd_done    pulse aligned with o_fram_hd of first frame on new gains
//   o_sat_cnt     (DL_AGC_SATCNT_EN only) clipped samples in previous frame
//
// Handshake: i_gain_upd is a single-cycle request; o_upd_busy is high from
// the cycle after the request until the cycle after the applying frame head,
// and i_gain must be held stable for that whole window.
//
// Optional feature macro: DL_AGC_SATCNT_EN
// -----------------------------------------------------------------------------
module dl_tdm_agc_gen2 #(
  parameter int NCH  = 8,
  parameter int DW   = 16,
  parameter int GW   = 18,
  parameter int FRAC = GW - 2
) (
  input  logic                   clk_245,
  input  logic                   asy_rst_n,
  input  logic                   i_fram_hd,
  input  logic [2*DW-1:0]        i_data,
  input  logic                   i_data_valid,
  input  logic [NCH*GW-1:0]      i_gain,
  input  logic                   i_gain_upd,
  output logic                   o_fram_hd,
  output logic                   o_data_valid,
  output logic [2*DW-1:0]        o_data,
  output logic [$clog2(NCH)-1:0] o_ch_idx,
  output logic                   o_sat,
  output logic                   o_upd_busy,
  output logic                   o_upd_done
`ifdef DL_AGC_SATCNT_EN
  ,
  output logic [15:0]            o_sat_cnt
`endif
);

  localparam int CW = $clog2(NCH);
  localparam int PW = DW + GW + 1;
  localparam logic [GW-1:0]        UNITY = GW'(1) << FRAC;
  localparam logic signed [PW-1:0] RND   = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [PW-1:0] SMAX  = PW'({1'b0, {(DW-1){1'b1}}});
  localparam logic signed [PW-1:0] SMIN  = ~SMAX;

  typedef enum logic {ST_IDLE, ST_PEND} upd_state_e;

  upd_state_e    state_q;
  logic [GW-1:0] gain_q [NCH];
  logic [CW-1:0] cnt_q, cnt_d, ch_cur;
  logic          apply;
  logic [GW-1:0] gain_sel;

  // cnt_q holds the channel of the most recent valid sample.
  always_comb begin
    ch_cur = '0;
    if (!i_fram_hd && (cnt_q != CW'(NCH-1))) ch_cur = cnt_q + CW'(1);
    cnt_d    = i_data_valid ? ch_cur : cnt_q;
    apply    = (state_q == ST_PEND) && i_data_valid && i_fram_hd;
    // The applying frame-head sample already uses the new gain.
    gain_sel = apply ? i_gain[int'(ch_cur)*GW +: GW] : gain_q[ch_cur];
  end

  // Update FSM and active gain bank.
  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      state_q <= ST_IDLE;
      for (int k = 0; k < NCH; k++) gain_q[k] <= UNITY;
    end else begin
      case (state_q)
        ST_IDLE: if (i_gain_upd) state_q <= ST_PEND;
        ST_PEND: begin
          // A request while pending is absorbed.
          if (i_data_valid && i_fram_hd) begin
            state_q <= ST_IDLE;
            for (int k = 0; k < NCH; k++) gain_q[k] <= i_gain[k*GW +: GW];
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_upd_busy = (state_q == ST_PEND);

  // Pipeline registers.
  logic                 s1_vld_q, s1_hd_q, s1_upd_q;
  logic [CW-1:0]        s1_ch_q;
  logic signed [DW-1:0] s1_i_q, s1_q_q;
  logic [GW-1:0]        s1_gain_q;
  logic                 s2_vld_q, s2_hd_q, s2_upd_q;
  logic [CW-1:0]        s2_ch_q;
  logic signed [PW-1:0] s2_pi_q, s2_pq_q;
  logic                 s3_vld_q, s3_hd_q, s3_upd_q;
  logic [CW-1:0]        s3_ch_q;
  logic signed [PW-1:0] s3_ri_q, s3_rq_q;
  logic                 out_vld_q, out_hd_q, out_done_q, out_sat_q;
  logic [CW-1:0]        out_ch_q;
  logic [2*DW-1:0]      out_data_q;

  logic signed [PW-1:0] mul_i, mul_q, rnd_i, rnd_q;
  logic [DW:0]          sat_i, sat_q;

  // Returns {clip, value}.
  function automatic logic [DW:0] sat_fn(input logic signed [PW-1:0] x);
    logic [DW:0] r;
    if (x > SMAX)      r = {1'b1, SMAX[DW-1:0]};
    else if (x < SMIN) r = {1'b1, SMIN[DW-1:0]};
    else               r = {1'b0, x[DW-1:0]};
    return r;
  endfunction

  // Gain is zero-extended so it is always treated as non-negative.
  assign mul_i = PW'(s1_i_q) * PW'($signed({1'b0, s1_gain_q}));
  assign mul_q = PW'(s1_q_q) * PW'($signed({1'b0, s1_gain_q}));
  assign rnd_i = (s2_pi_q + RND) >>> FRAC;
  assign rnd_q = (s2_pq_q + RND) >>> FRAC;
  assign sat_i = sat_fn(s3_ri_q);
  assign sat_q = sat_fn(s3_rq_q);

  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      cnt_q      <= '0;
      s1_vld_q   <= 1'b0; s1_hd_q <= 1'b0; s1_upd_q <= 1'b0; s1_ch_q <= '0;
      s1_i_q     <= '0;   s1_q_q  <= '0;   s1_gain_q <= '0;
      s2_vld_q   <= 1'b0; s2_hd_q <= 1'b0; s2_upd_q <= 1'b0; s2_ch_q <= '0;
      s2_pi_q    <= '0;   s2_pq_q <= '0;
      s3_vld_q   <= 1'b0; s3_hd_q <= 1'b0; s3_upd_q <= 1'b0; s3_ch_q <= '0;
      s3_ri_q    <= '0;   s3_rq_q <= '0;
      out_vld_q  <= 1'b0; out_hd_q <= 1'b0; out_done_q <= 1'b0; out_sat_q <= 1'b0;
      out_ch_q   <= '0;   out_data_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      // S1
      s1_vld_q   <= i_data_valid;
      s1_hd_q    <= i_data_valid & i_fram_hd;
      s1_upd_q   <= apply;
      s1_ch_q    <= ch_cur;
      s1_i_q     <= i_data[2*DW-1:DW];
      s1_q_q     <= i_data[DW-1:0];
      s1_gain_q  <= gain_sel;
      // S2
      s2_vld_q   <= s1_vld_q; s2_hd_q <= s1_hd_q; s2_upd_q <= s1_upd_q; s2_ch_q <= s1_ch_q;
      s2_pi_q    <= mul_i;    s2_pq_q <= mul_q;
      // S3
      s3_vld_q   <= s2_vld_q; s3_hd_q <= s2_hd_q; s3_upd_q <= s2_upd_q; s3_ch_q <= s2_ch_q;
      s3_ri_q    <= rnd_i;    s3_rq_q <= rnd_q;
      // S4: everything but the strobes is forced to 0 on idle cycles.
      out_vld_q  <= s3_vld_q;
      out_hd_q   <= s3_hd_q;
      out_done_q <= s3_upd_q;
      out_ch_q   <= s3_vld_q ? s3_ch_q : '0;
      out_sat_q  <= s3_vld_q & (sat_i[DW] | sat_q[DW]);
      out_data_q <= s3_vld_q ? {sat_i[DW-1:0], sat_q[DW-1:0]} : '0;
    end
  end

  assign o_fram_hd    = out_hd_q;
  assign o_data_valid = out_vld_q;
  assign o_data       = out_data_q;
  assign o_ch_idx     = out_ch_q;
  assign o_sat        = out_sat_q;
  assign o_upd_done   = out_done_q;

`ifdef DL_AGC_SATCNT_EN
  // The frame-head sample itself counts towards the new frame.
  logic [15:0] satcnt_q, satcnt_out_q;
  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      satcnt_q     <= '0;
      satcnt_out_q <= '0;
    end else if (out_vld_q && out_hd_q) begin
      satcnt_out_q <= satcnt_q;
      satcnt_q     <= {15'd0, out_sat_q};
    end else if (out_vld_q && out_sat_q && (satcnt_q != 16'hFFFF)) begin
      satcnt_q     <= satcnt_q + 16'd1;
    end
  end
  assign o_sat_cnt = satcnt_out_q;
`endif

endmodule

// File: tb/tb_dl_tdm_agc_gen2.sv
// -----------------------------------------------------------------------------
// tb_dl_tdm_agc_gen2
// Bench for dl_tdm_agc_gen2 (NCH=8, DW=16, GW=18). A reference model tracks
// channel index, pending update and gain bank; every driven valid sample
// pushes its expected output (with expected arrival cycle) to exp_q, and a
// negedge monitor pops and compares whenever o_data_valid is high.
// -----------------------------------------------------------------------------
module tb_dl_tdm_agc_gen2;

  localparam int NCH = 8;
  localparam int DW  = 16;
  localparam int GW  = 18;
  localparam logic [GW-1:0] UNITY = 18'h10000;

  // ---------------- clock / reset ----------------
  logic clk_245 = 1'b0;
  logic asy_rst_n = 1'b0;
  always #2 clk_245 = ~clk_245;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk_245) cyc <= cyc + 32'd1;

  // ---------------- DUT ----------------
  logic              i_fram_hd = 1'b0;
  logic [2*DW-1:0]   i_data = '0;
  logic              i_data_valid = 1'b0;
  logic [NCH*GW-1:0] gain_vec;
  logic              i_gain_upd = 1'b0;
  logic              o_fram_hd, o_data_valid, o_sat, o_upd_busy, o_upd_done;
  logic [2*DW-1:0]   o_data;
  logic [2:0]        o_ch_idx;
`ifdef DL_AGC_SATCNT_EN
  logic [15:0]       o_sat_cnt;
`endif

  dl_tdm_agc_gen2 #(.NCH(NCH), .DW(DW), .GW(GW)) dut (
    .clk_245      (clk_245),
    .asy_rst_n    (asy_rst_n),
    .i_fram_hd    (i_fram_hd),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .i_gain       (gain_vec),
    .i_gain_upd   (i_gain_upd),
    .o_fram_hd    (o_fram_hd),
    .o_data_valid (o_data_valid),
    .o_data       (o_data),
    .o_ch_idx     (o_ch_idx),
    .o_sat        (o_sat),
    .o_upd_busy   (o_upd_busy),
    .o_upd_done   (o_upd_done)
`ifdef DL_AGC_SATCNT_EN
    ,
    .o_sat_cnt    (o_sat_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        hd;
    logic [2:0]  ch;
    logic [31:0] data;
    logic        sat;
    logic        done;
    logic [31:0] cyc;
  } exp_t;
  localparam int EW = $bits(exp_t);
  logic [EW-1:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  always @(negedge clk_245) begin
    if (asy_rst_n) begin
      n_cmp++;
      if (o_data_valid) begin
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL out_unexpected: got data=%h ch=%0d at cyc %0d, expected no sample", o_data, o_ch_idx, cyc);
        end else begin
          exp_t e, g;
          e = exp_t'(exp_q.pop_front());
          g = '{hd: o_fram_hd, ch: o_ch_idx, data: o_data, sat: o_sat, done: o_upd_done, cyc: cyc};
          if (g !== e) begin
            n_err++;
            $display("FAIL out_sample: got hd=%0b ch=%0d data=%h sat=%0b done=%0b cyc=%0d, expected hd=%0b ch=%0d data=%h sat=%0b done=%0b cyc=%0d",
                     g.hd, g.ch, g.data, g.sat, g.done, g.cyc, e.hd, e.ch, e.data, e.sat, e.done, e.cyc);
          end
        end
      end else if ({o_fram_hd, o_data, o_ch_idx, o_sat, o_upd_done} != '0) begin
        n_err++;
        $display("FAIL idle_zero: got hd=%0b data=%h ch=%0d sat=%0b done=%0b, expected all 0",
                 o_fram_hd, o_data, o_ch_idx, o_sat, o_upd_done);
      end
    end
  end

  // ---------------- reference model ----------------
  int            m_cnt;
  logic          m_pend;
  logic [GW-1:0] m_gain [NCH];

  // Returns {clip, value}: round half up by adding 0.5 then flooring.
  function automatic logic [16:0] model_scale(input logic [15:0] d, input logic [17:0] g);
    longint p;
    p = longint'($signed(d)) * longint'(g);
    p = (p + 64'sd32768) >>> 16;
    if (p > 64'sd32767)  return {1'b1, 16'h7FFF};
    if (p < -64'sd32768) return {1'b1, 16'h8000};
    return {1'b0, p[15:0]};
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_pend = 1'b0;
    for (int k = 0; k < NCH; k++) m_gain[k] = UNITY;
  endtask

  // ---------------- driver ----------------
  // Drives one cycle; when ovr is set, ovr_val = {sat, data} replaces the
  // model's arithmetic result with a hand-computed one.
  task automatic drive(input logic v, input logic hd, input logic [15:0] di, input logic [15:0] dq,
                       input logic upd, input logic ovr, input logic [32:0] ovr_val);
    exp_t e;
    logic apply;
    int   idx;
    logic [16:0] ri, rq;
    i_data_valid = v;
    i_fram_hd    = hd;
    i_data       = {di, dq};
    i_gain_upd   = upd;
    apply = m_pend && v && hd;
    if (apply) for (int k = 0; k < NCH; k++) m_gain[k] = gain_vec[k*GW +: GW];
    if (v) begin
      idx   = hd ? 0 : ((m_cnt == NCH-1) ? 0 : m_cnt + 1);
      m_cnt = idx;
      ri = model_scale(di, m_gain[idx]);
      rq = model_scale(dq, m_gain[idx]);
      e.hd   = hd;
      e.ch   = 3'(idx);
      e.data = ovr ? ovr_val[31:0] : {ri[15:0], rq[15:0]};
      e.sat  = ovr ? ovr_val[32]   : (ri[16] | rq[16]);
      e.done = apply;
      e.cyc  = cyc + 32'd4;
      exp_q.push_back(e);
    end
    if (apply)    m_pend = 1'b0;
    else if (upd) m_pend = 1'b1;
    @(posedge clk_245);
    #1;
    check1("upd_busy", {31'd0, o_upd_busy}, {31'd0, m_pend});
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 33'h0);
  endtask

  // ---------------- vector table: one row per channel ----------------
  typedef struct {
    logic [17:0] g;
    logic [15:0] i;
    logic [15:0] q;
    logic [15:0] ei;
    logic [15:0] eq;
    logic        es;
  } vec_t;
  vec_t tbl [NCH];

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] di, dq;
    logic [31:0] d32;

    tbl[0] = '{18'h10000, 16'h1234, 16'hEDCC, 16'h1234, 16'hEDCC, 1'b0}; // unity
    tbl[1] = '{18'h20000, 16'h7000, 16'h8000, 16'h7FFF, 16'h8000, 1'b1}; // x2, both clip
    tbl[2] = '{18'h08000, 16'h0003, 16'hFFFD, 16'h0002, 16'hFFFF, 1'b0}; // x0.5: 1.5->2, -1.5->-1
    tbl[3] = '{18'h00000, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 1'b0}; // zero gain
    tbl[4] = '{18'h3FFFF, 16'h0001, 16'hFFFF, 16'h0004, 16'hFFFC, 1'b0}; // max gain, small data
    tbl[5] = '{18'h18000, 16'h4000, 16'hC000, 16'h6000, 16'hA000, 1'b0}; // x1.5 exact
    tbl[6] = '{18'h0C000, 16'h0002, 16'hFFFE, 16'h0002, 16'hFFFF, 1'b0}; // x0.75 halves
    tbl[7] = '{18'h1FFFF, 16'h5000, 16'h0100, 16'h7FFF, 16'h0200, 1'b1}; // I clips only

    for (int k = 0; k < NCH; k++) gain_vec[k*GW +: GW] = UNITY;
    model_reset();

    // Reset state
    asy_rst_n = 1'b0;
    repeat (3) @(posedge clk_245);
    #1;
    check1("rst_valid", {31'd0, o_data_valid}, 32'd0);
    check1("rst_data",  o_data, 32'd0);
    check1("rst_hd",    {31'd0, o_fram_hd}, 32'd0);
    check1("rst_ch",    {29'd0, o_ch_idx}, 32'd0);
    check1("rst_sat",   {31'd0, o_sat}, 32'd0);
    check1("rst_busy",  {31'd0, o_upd_busy}, 32'd0);
    check1("rst_done",  {31'd0, o_upd_done}, 32'd0);
`ifdef DL_AGC_SATCNT_EN
    check1("rst_satcnt", {16'd0, o_sat_cnt}, 32'd0);
`endif
    asy_rst_n = 1'b1;
    idle(2);

    // Unity path: data passes unchanged, channels 0..7
    for (int k = 0; k < NCH; k++)
      drive(1'b1, k == 0, 16'h1234, 16'hEDCC, 1'b0, 1'b1, {1'b0, 32'h1234EDCC});
    idle(2);

    // Update alignment: request mid-frame, ch2 doubled only from the next frame
    gain_vec[2*GW +: GW] = 18'h20000;
    for (int k = 0; k < NCH; k++)
      drive(1'b1, k == 0, 16'h1000, 16'hF000, k == 3, 1'b1, {1'b0, 32'h1000F000});
    check1("busy_pending", {31'd0, o_upd_busy}, 32'd1);
    for (int k = 0; k < NCH; k++)
      drive(1'b1, k == 0, 16'h1000, 16'hF000, 1'b0, 1'b1,
            (k == 2) ? {1'b0, 32'h2000E000} : {1'b0, 32'h1000F000});
    idle(3);

    // Table: distinct gain per channel, hand-computed results
    for (int k = 0; k < NCH; k++) gain_vec[k*GW +: GW] = tbl[k].g;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 33'h0);
    for (int k = 0; k < NCH; k++)
      drive(1'b1, k == 0, tbl[k].i, tbl[k].q, 1'b0, 1'b1, {tbl[k].es, tbl[k].ei, tbl[k].eq});
    idle(2);

    // Valid gaps, head without valid ignored, re-sync after 5 samples,
    // update request coincident with a head in IDLE applies one head later.
    drive(1'b1, 1'b1, 16'h0100, 16'h0200, 1'b0, 1'b0, 33'h0);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 33'h0);
    drive(1'b1, 1'b0, 16'h0101, 16'h0201, 1'b0, 1'b0, 33'h0);
    drive(1'b0, 1'b1, 16'h7777, 16'h7777, 1'b0, 1'b0, 33'h0);
    drive(1'b1, 1'b0, 16'h0102, 16'h0202, 1'b0, 1'b0, 33'h0);
    drive(1'b1, 1'b0, 16'h0103, 16'h0203, 1'b0, 1'b0, 33'h0);
    drive(1'b1, 1'b0, 16'h0104, 16'h0204, 1'b0, 1'b0, 33'h0);
    for (int k = 0; k < NCH; k++) gain_vec[k*GW +: GW] = UNITY;
    drive(1'b1, 1'b1, 16'h0105, 16'h0205, 1'b1, 1'b0, 33'h0);
    for (int k = 1; k < NCH; k++)
      drive(1'b1, 1'b0, 16'h0110 + 16'(k), 16'h0210 + 16'(k), 1'b0, 1'b0, 33'h0);
    for (int k = 0; k < NCH; k++)
      drive(1'b1, k == 0, 16'h0300 + 16'(k), 16'hFD00 - 16'(k), 1'b0, 1'b0, 33'h0);
    idle(2);

    // Random frames with random gaps and random gain updates
    for (int f = 0; f < 4; f++) begin
      int k;
      k = 0;
      while (k < NCH) begin
        if ($urandom_range(0, 3) == 0) begin
          idle(1);
        end else begin
          logic upd;
          upd = 1'b0;
          if (f < 3 && !m_pend && $urandom_range(0, 5) == 0) begin
            for (int c = 0; c < NCH; c++) gain_vec[c*GW +: GW] = 18'($urandom_range(0, 262143));
            upd = 1'b1;
          end
          drive(1'b1, k == 0, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                upd, 1'b0, 33'h0);
          k++;
        end
      end
    end
    idle(6);

    // Reset while an update is pending: in-flight samples are discarded,
    // gains revert to unity and no o_upd_done appears.
    for (int k = 0; k < NCH; k++) gain_vec[k*GW +: GW] = 18'h20000;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 33'h0);
    drive(1'b1, 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0, 33'h0);
    drive(1'b1, 1'b0, 16'h3333, 16'h4444, 1'b0, 1'b0, 33'h0);
    asy_rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check1("rst2_busy",  {31'd0, o_upd_busy}, 32'd0);
    check1("rst2_valid", {31'd0, o_data_valid}, 32'd0);
    check1("rst2_done",  {31'd0, o_upd_done}, 32'd0);
    check1("rst2_data",  o_data, 32'd0);
`ifdef DL_AGC_SATCNT_EN
    check1("rst2_satcnt", {16'd0, o_sat_cnt}, 32'd0);
`endif
    repeat (2) @(posedge clk_245);
    #1;
    asy_rst_n = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      d32 = $urandom();
      di = d32[31:16];
      dq = d32[15:0];
      drive(1'b1, k == 0, di, dq, 1'b0, 1'b1, {1'b0, di, dq});
    end
    idle(8);

    // Drain: every expected sample must have come out
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk_245);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d samples outstanding, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
